// File: rtl/avalon_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : avalon_led_ctrl
// Description : Avalon-MM LED/GPIO output controller with set/clear, blink, PWM
// Revision    : 1.0
// ============================================================================
module avalon_led_ctrl #(
    parameter int               WIDTH       = 8,
    parameter int               PRESCALE    = 50000,
    parameter int               PWM_BITS    = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam int                  c_PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PRE_W-1:0]  c_PRE_MAX   = c_PRE_W'(PRESCALE - 1);
    localparam logic [PWM_BITS:0]   c_DUTY_FULL = {1'b1, {PWM_BITS{1'b0}}};

    localparam logic [2:0] c_A_DATA   = 3'd0;
    localparam logic [2:0] c_A_BLINK  = 3'd1;
    localparam logic [2:0] c_A_PERIOD = 3'd2;
    localparam logic [2:0] c_A_DUTY   = 3'd3;
    localparam logic [2:0] c_A_SET    = 3'd4;
    localparam logic [2:0] c_A_CLEAR  = 3'd5;
    localparam logic [2:0] c_A_STATUS = 3'd6;

    logic [WIDTH-1:0]    r_data;
    logic [WIDTH-1:0]    r_blink;
    logic [15:0]         r_period;
    logic [PWM_BITS:0]   r_duty;
    logic [c_PRE_W-1:0]  r_pre_cnt;
    logic [15:0]         r_blk_cnt;
    logic                r_phase;
    logic [PWM_BITS-1:0] r_pwm_cnt;

    logic             w_wr;
    logic             w_tick;
    logic             w_pwm_on;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_mask;

    assign w_wr     = chipselect & ~write_n;
    assign w_wdata  = writedata[WIDTH-1:0];
    assign w_tick   = (r_pre_cnt == c_PRE_MAX);
    assign w_pwm_on = (r_duty > {1'b0, r_pwm_cnt});
    // Blinking channels follow the phase, the rest stay at their static level.
    assign w_mask   = ~r_blink | {WIDTH{r_phase}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data   <= RESET_VALUE;
            r_blink  <= '0;
            r_period <= '0;
            r_duty   <= c_DUTY_FULL;
        end else if (w_wr) begin
            case (address)
                c_A_DATA:   r_data   <= w_wdata;
                c_A_BLINK:  r_blink  <= w_wdata;
                c_A_PERIOD: r_period <= writedata[15:0];
                c_A_DUTY:   r_duty   <= writedata[PWM_BITS:0];
                c_A_SET:    r_data   <= r_data | w_wdata;
                c_A_CLEAR:  r_data   <= r_data & ~w_wdata;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= '0;
        end else begin
            r_pre_cnt <= w_tick ? '0 : r_pre_cnt + 1'b1;
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    // A PERIOD write restarts the blink cycle and takes priority over a tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blk_cnt <= '0;
            r_phase   <= 1'b1;
        end else if ((w_wr && address == c_A_PERIOD) || r_period == 16'd0) begin
            r_blk_cnt <= '0;
            r_phase   <= 1'b1;
        end else if (w_tick) begin
            if (r_blk_cnt == r_period - 16'd1) begin
                r_blk_cnt <= '0;
                r_phase   <= ~r_phase;
            end else begin
                r_blk_cnt <= r_blk_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= '0;
        end else begin
            out_port <= r_data & w_mask & {WIDTH{w_pwm_on}};
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            c_A_DATA:   readdata[WIDTH-1:0]  = r_data;
            c_A_BLINK:  readdata[WIDTH-1:0]  = r_blink;
            c_A_PERIOD: readdata[15:0]       = r_period;
            c_A_DUTY:   readdata[PWM_BITS:0] = r_duty;
            c_A_STATUS: readdata[1:0]        = {w_tick, r_phase};
            default:    ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_avalon_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_led_ctrl
// Description : Directed self-checking bench for avalon_led_ctrl
// Revision    : 1.0
// ============================================================================
module tb_avalon_led_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic [31:0] readdata_d;
    logic [7:0]  out_port_d;

    int n_checks = 0;
    int n_errors = 0;

    avalon_led_ctrl #(
        .WIDTH       (8),
        .PRESCALE    (4),
        .PWM_BITS    (4),
        .RESET_VALUE (8'hA5)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    // Default-parameter instance, used for the 8-bit PWM duty reset value.
    avalon_led_ctrl u_dut_def (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata_d),
        .out_port   (out_port_d)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic measure_toggle(output int n);
        logic prev;
        prev = out_port[0];
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (out_port[0] == prev && n < 100);
    endtask

    task automatic count_on(input int cycles, output int on, output int off);
        on  = 0;
        off = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (out_port == 8'hFF) on++;
            else if (out_port == 8'h00) off++;
        end
    endtask

    // Waits at negedges until STATUS bit sel equals val; returns 0 on timeout.
    task automatic wait_status(input int sel, input logic val, output logic ok);
        ok = 1'b0;
        address = 3'd6;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (readdata[sel] == val) ok = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  bad;
        logic        ok;
        int          n;
        int          on;
        int          off;

        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = '0;

        // Reset state
        #12;
        check("rst_out", {24'd0, out_port}, 32'h0);
        check("rst_out_def", {24'd0, out_port_d}, 32'h0);
        bus_read(3'd0, rd); check("rst_data", rd, 32'hA5);
        bus_read(3'd1, rd); check("rst_blink", rd, 32'h0);
        bus_read(3'd2, rd); check("rst_period", rd, 32'h0);
        bus_read(3'd3, rd); check("rst_duty", rd, 32'h10);
        check("rst_duty_def", readdata_d, 32'h100);
        bus_read(3'd7, rd); check("rsvd_read", rd, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_out", {24'd0, out_port}, 32'hA5);

        // DATA / SET / CLEAR with one-cycle output lag
        bus_write(3'd0, 32'h0F);
        check("data_lag_old", {24'd0, out_port}, 32'hA5);
        @(posedge clk); #1;
        check("data_lag_new", {24'd0, out_port}, 32'h0F);
        bus_write(3'd4, 32'hF0);
        bus_read(3'd0, rd); check("set_data", rd, 32'hFF);
        bus_write(3'd5, 32'h3C);
        bus_read(3'd0, rd); check("clear_data", rd, 32'hC3);
        check("clear_lag_old", {24'd0, out_port}, 32'hFF);
        @(posedge clk); #1;
        check("clear_lag_new", {24'd0, out_port}, 32'hC3);
        bus_read(3'd4, rd); check("set_reads0", rd, 32'h0);
        bus_read(3'd5, rd); check("clear_reads0", rd, 32'h0);
        bus_write(3'd4, 32'hFFFF_FF00);
        bus_read(3'd0, rd); check("set_upper_ignored", rd, 32'hC3);
        bus_write(3'd7, 32'h0);
        bus_write(3'd6, 32'h0);
        bus_read(3'd0, rd); check("unmapped_wr_ignored", rd, 32'hC3);

        // Blink: PERIOD=3 ticks of 4 clk -> bit0 toggles every 12 clk
        bus_write(3'd0, 32'hFF);
        bus_write(3'd1, 32'h01);
        bus_write(3'd2, 32'd3);
        bus_read(3'd2, rd); check("period_read", rd, 32'd3);
        measure_toggle(n);
        measure_toggle(n); check("blink_half1", n, 32'd12);
        measure_toggle(n); check("blink_half2", n, 32'd12);
        check("blink_steady_bits", {25'd0, out_port[7:1]}, 32'h7F);

        // PERIOD write on a tick edge with phase 0 and blk_cnt 0
        bus_write(3'd2, 32'd2);
        wait_status(0, 1'b1, ok);
        if (ok) wait_status(0, 1'b0, ok);
        if (ok) wait_status(1, 1'b1, ok);
        check("tick_align_found", {31'd0, ok}, 32'd1);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'd2;
        writedata  = 32'd3;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        bus_read(3'd6, rd); check("period_wr_on_tick_phase", {31'd0, rd[0]}, 32'd1);
        repeat (11) @(posedge clk);
        #1;
        check("period_wr_phase_held", {31'd0, readdata[0]}, 32'd1);
        @(posedge clk); #1;
        check("period_wr_phase_toggle", {31'd0, readdata[0]}, 32'd0);

        // PERIOD=0 disables blinking
        bus_write(3'd2, 32'd0);
        bus_write(3'd1, 32'hFF);
        bus_write(3'd0, 32'h5A);
        repeat (2) @(posedge clk);
        bad = 8'h5A;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_port != 8'h5A) bad = out_port;
        end
        check("period0_steady", {24'd0, bad}, 32'h5A);

        // PWM brightness
        bus_write(3'd1, 32'h00);
        bus_write(3'd0, 32'hFF);
        bus_write(3'd3, 32'd4);
        repeat (2) @(posedge clk);
        count_on(16, on, off);
        check("pwm4_on", on, 32'd4);
        check("pwm4_off", off, 32'd12);
        bus_write(3'd3, 32'd0);
        repeat (2) @(posedge clk);
        count_on(32, on, off);
        check("pwm0_on", on, 32'd0);
        bus_write(3'd3, 32'h20);
        bus_read(3'd3, rd); check("duty_truncate", rd, 32'h0);
        bus_write(3'd3, 32'd16);
        repeat (2) @(posedge clk);
        count_on(32, on, off);
        check("pwm16_on", on, 32'd32);
        bus_write(3'd3, 32'd31);
        repeat (2) @(posedge clk);
        count_on(32, on, off);
        check("pwm31_on", on, 32'd32);

        // Asynchronous reset in the middle of blinking with half duty
        bus_write(3'd3, 32'd8);
        bus_write(3'd1, 32'h01);
        bus_write(3'd2, 32'd1);
        repeat (20) @(posedge clk);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(posedge clk); #1;
            if (out_port != 8'h00) ok = 1'b1;
        end
        check("pre_reset_active", {31'd0, ok}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_out", {24'd0, out_port}, 32'h0);
        bus_read(3'd0, rd); check("async_rst_data", rd, 32'hA5);
        bus_read(3'd1, rd); check("async_rst_blink", rd, 32'h0);
        bus_read(3'd2, rd); check("async_rst_period", rd, 32'h0);
        bus_read(3'd3, rd); check("async_rst_duty", rd, 32'h10);
        bus_read(3'd6, rd); check("async_rst_status", rd, 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
